// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID operand that depends on a load sitting in EX.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    // Register zero is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        hazard = ex_mem_read
              && (ex_rd != REG_ADDR_W'(REG_ZERO))
              && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline buffer/PC sequencer: load-use stalls, branch flushes, multi-cycle EX hold, memory freeze.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mc_op,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     flush_events
);

    localparam bit          MC_ON    = (MC_LAT > 1);
    localparam int unsigned MC_CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [MC_CNT_W-1:0] MC_RELOAD = MC_CNT_W'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

    state_t              state_q;
    logic [MC_CNT_W-1:0] mc_cnt_q;
    logic                load_use;
    logic                mc_hold;
    logic                branch_flush;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (load_use)
    );

    // The release cycle (MC_WAIT, counter 0) masks the multi-cycle rule.
    always_comb begin
        mc_hold = MC_ON && (((state_q == RUN) && ex_mc_op)
                         || ((state_q == MC_WAIT) && (mc_cnt_q != '0)));
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        branch_flush = 1'b0;
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush}         = '1;
        end else if (mem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (mc_hold) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else if (!mem_busy) begin
            case (state_q)
                RUN: begin
                    if (MC_ON && ex_mc_op) begin
                        state_q  <= MC_WAIT;
                        mc_cnt_q <= MC_RELOAD;
                    end
                end
                MC_WAIT: begin
                    if (mc_cnt_q != '0) begin
                        mc_cnt_q <= mc_cnt_q - 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (branch_flush) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    logic unused_branch_flush;
    assign unused_branch_flush = branch_flush;
    assign stall_cycles        = '0;
    assign flush_events        = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle, freeze and reset sequences.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rt = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_mc_op = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [31:0] stall_cycles, flush_events;
    logic [7:0]  ctl;

    int n_checks = 0;
    int n_fails  = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MC_LAT     (4),
        .PERF_W     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_mc_op     (ex_mc_op),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

    // Control vector layout: {pc, ifid, idex, exmem, memwb en | ifid, idex, exmem flush}
    localparam logic [7:0] C_IDLE  = 8'b11111_000;
    localparam logic [7:0] C_RST   = 8'b00000_111;
    localparam logic [7:0] C_FRZ   = 8'b00000_000;
    localparam logic [7:0] C_LU    = 8'b00011_010;
    localparam logic [7:0] C_BR    = 8'b11111_110;
    localparam logic [7:0] C_MC    = 8'b00011_001;
    localparam logic [7:0] M_ALL   = 8'hff;
    localparam logic [7:0] M_NOIDX = 8'b11011_111;

    typedef struct {
        logic       rst, busy, mr, mc, br, ut;
        logic [4:0] rs, rt, rd;
        logic [7:0] exp, mask;
        string      nm;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input string nm, input logic r, input logic b, input logic mr,
                                input logic br, input logic ut, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [7:0] exp, input logic [7:0] mask);
        vec_t v;
        v.nm = nm; v.rst = r; v.busy = b; v.mr = mr; v.mc = 1'b0; v.br = br; v.ut = ut;
        v.rs = rs; v.rt = rt; v.rd = rd; v.exp = exp; v.mask = mask;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] mask);
        n_checks++;
        if ((act & mask) !== (exp & mask)) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", nm, act & mask, exp & mask);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
        ex_mc_op = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] perf_exp(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    initial begin
        int exp_stall = 0;
        int exp_flush = 0;

        vecs[0]  = mk("reset",        1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RST,  M_ALL);
        vecs[1]  = mk("idle",         0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_IDLE, M_ALL);
        vecs[2]  = mk("lu_rs",        0, 0, 1, 0, 0, 5'd5, 5'd0, 5'd5, C_LU,   M_NOIDX);
        vecs[3]  = mk("lu_resolved",  0, 0, 0, 0, 0, 5'd5, 5'd0, 5'd5, C_IDLE, M_ALL);
        vecs[4]  = mk("lu_reg_zero",  0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_IDLE, M_ALL);
        vecs[5]  = mk("lu_rt_unused", 0, 0, 1, 0, 0, 5'd3, 5'd7, 5'd7, C_IDLE, M_ALL);
        vecs[6]  = mk("lu_rt_used",   0, 0, 1, 0, 1, 5'd3, 5'd7, 5'd7, C_LU,   M_NOIDX);
        vecs[7]  = mk("branch",       0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, C_BR,   M_ALL);
        vecs[8]  = mk("branch_over_lu", 0, 0, 1, 1, 0, 5'd9, 5'd0, 5'd9, C_BR, M_ALL);
        vecs[9]  = mk("freeze_lu",    0, 1, 1, 0, 0, 5'd9, 5'd0, 5'd9, C_FRZ,  M_ALL);
        vecs[10] = mk("no_load",      0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd4, C_IDLE, M_ALL);

        for (int i = 0; i < 11; i++) begin
            next_cycle();
            rst = vecs[i].rst; mem_busy = vecs[i].busy; ex_mem_read = vecs[i].mr;
            ex_mc_op = vecs[i].mc; branch_taken = vecs[i].br; id_uses_rt = vecs[i].ut;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
            @(negedge clk);
            chk(vecs[i].nm, 32'(ctl), 32'(vecs[i].exp), 32'(vecs[i].mask));
            if (vecs[i].rst) begin
                exp_stall = 0;
                exp_flush = 0;
            end else begin
                if (!vecs[i].exp[7]) exp_stall++;
                if (vecs[i].exp[2:1] == 2'b11) exp_flush++;
            end
        end
        next_cycle();
        idle_inputs();
        chk("table_stall_cycles", stall_cycles, perf_exp(exp_stall), 32'hffffffff);
        chk("table_flush_events", flush_events, perf_exp(exp_flush), 32'hffffffff);

        // Multi-cycle op held: three hold cycles, then release with everything enabled.
        do_reset();
        ex_mc_op = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mc_hold_%0d", k), 32'(ctl), 32'(C_MC), 32'(M_ALL));
            next_cycle();
            chk($sformatf("mc_state_%0d", k), 32'(dut.state_q), 32'(MC_WAIT), 32'h1);
            chk($sformatf("mc_cnt_%0d", k), 32'(dut.mc_cnt_q), 32'(2 - k), 32'hffffffff);
        end
        @(negedge clk);
        chk("mc_release", 32'(ctl), 32'(C_IDLE), 32'(M_ALL));
        next_cycle();
        ex_mc_op = 1'b0;
        chk("mc_back_to_run", 32'(dut.state_q), 32'(RUN), 32'h1);
        chk("mc_stall_cycles", stall_cycles, perf_exp(3), 32'hffffffff);

        // Freeze while in MC_WAIT with one hold cycle remaining.
        do_reset();
        ex_mc_op = 1'b1;
        next_cycle();
        next_cycle();
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("freeze_ctl_%0d", k), 32'(ctl), 32'(C_FRZ), 32'(M_ALL));
            chk($sformatf("freeze_cnt_%0d", k), 32'(dut.mc_cnt_q), 32'd1, 32'hffffffff);
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        chk("post_freeze_hold", 32'(ctl), 32'(C_MC), 32'(M_ALL));
        next_cycle();
        chk("post_freeze_cnt", 32'(dut.mc_cnt_q), 32'd0, 32'hffffffff);
        @(negedge clk);
        chk("post_freeze_release", 32'(ctl), 32'(C_IDLE), 32'(M_ALL));
        next_cycle();
        ex_mc_op = 1'b0;
        chk("freeze_state_run", 32'(dut.state_q), 32'(RUN), 32'h1);
        chk("freeze_stall_cycles", stall_cycles, perf_exp(6), 32'hffffffff);
        chk("freeze_flush_events", flush_events, perf_exp(0), 32'hffffffff);

        // Reset asserted in the middle of a multi-cycle op.
        do_reset();
        ex_mc_op = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_ctl_%0d", k), 32'(ctl), 32'(C_RST), 32'(M_ALL));
            next_cycle();
        end
        rst = 1'b0;
        ex_mc_op = 1'b0;
        chk("rst_mid_state", 32'(dut.state_q), 32'(RUN), 32'h1);
        chk("rst_mid_cnt", 32'(dut.mc_cnt_q), 32'd0, 32'hffffffff);
        chk("rst_mid_stall", stall_cycles, 32'd0, 32'hffffffff);
        chk("rst_mid_flush", flush_events, 32'd0, 32'hffffffff);
        @(negedge clk);
        chk("rst_mid_idle", 32'(ctl), 32'(C_IDLE), 32'(M_ALL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the four inter-stage pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register of the 5-stage core.
- Generates per-stage capture-enable and flush (bubble) controls for:
  - load-use stalls;
  - taken-branch flushes;
  - multi-cycle EX operations, via a 2-state FSM plus a latency counter;
  - a global freeze while data memory is busy.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op. Must be >= 1; a value of 1 disables multi-cycle handling.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- ex_mc_op  in  1  the EX instruction is multi-cycle (mul/div).
- branch_taken  in  1  branch resolved taken in EX.
- mem_busy  in  1  data memory is not ready this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  capture enable (1 = load the next value).
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (zero) instead of data. Flush overrides the matching enable.
- stall_cycles  out  PERF_W  count of cycles with pc_en=0.
- flush_events  out  PERF_W  count of branch flushes.

Behaviour:
- Signal timing:
  - All inputs are sampled each cycle.
  - All control outputs are combinational from the current state, the counter and the inputs. They act on the same clock edge.
  - State: RUN or MC_WAIT. Counter: mc_cnt, width clog2(MC_LAT) (minimum 1).
- While rst=1:
  - All *_en=0 and all *_flush=1.
  - Next state is RUN, mc_cnt=0, performance counters cleared.
  - A reset asserted in MC_WAIT abandons the op.
- Freeze (mem_busy=1, any state, highest priority):
  - All *_en=0 and all *_flush=0.
  - State, mc_cnt and the hazard outcome are held. Hazards are re-evaluated on the first cycle after mem_busy drops.
- RUN, when no freeze applies. Checks in priority order:
  1. Multi-cycle op (ex_mc_op=1 and MC_LAT>1):
     - pc_en=ifid_en=idex_en=0.
     - exmem_en=1 with exmem_flush=1.
     - memwb_en=1.
     - mc_cnt<=MC_LAT-2, next state MC_WAIT.
  2. Taken branch (branch_taken=1):
     - ifid_flush=1, idex_flush=1.
     - All enables 1, so the PC loads the branch target.
     - flush_events increments.
  3. Load-use:
     - Condition: ex_mem_read=1 and ex_rd!=0 and (ex_rd==id_rs, or id_uses_rt=1 and ex_rd==id_rt).
     - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
     - Exactly one bubble. The next cycle resolves naturally because the load has moved to MEM.
  4. Otherwise all enables are 1 and all flushes are 0.
- MC_WAIT, when no freeze applies:
  - If mc_cnt!=0: the same controls as entering the multi-cycle op, and mc_cnt decrements.
  - If mc_cnt==0 (release cycle): evaluated as RUN rules 2-4 with rule 1 masked; next state RUN.
  - Total front-end hold is MC_LAT-1 cycles. The op captures into EX/MEM at the end of cycle MC_LAT.
- Register address 0 never causes a hazard.
- stall_cycles increments on every non-reset cycle with pc_en=0, including freeze cycles.
- Both performance counters wrap modulo 2^PERF_W.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined: stall_cycles and flush_events are implemented as described above.
- When undefined: no counter flops are built; both outputs are tied to 0 and the ports remain present.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum {RUN, MC_WAIT};
  - the REG_ADDR_W default;
  - the register-zero constant.
- One natural sub-module: load_use_detect, a combinational comparator of id_rs/id_rt/id_uses_rt against ex_rd/ex_mem_read, outputting a hazard bit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle.
  - Required: that cycle pc_en=0, ifid_en=0, idex_flush=1; the next cycle (ex_mem_read=0) all enables are 1.
- Register zero and rt use:
  - ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall.
  - ex_rd=7, id_rt=7 with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
- Multi-cycle op: MC_LAT=4, ex_mc_op=1 held.
  - Required: 3 cycles of pc_en=0 with exmem_flush=1; the 4th cycle has all enables 1 and the state returns to RUN.
- Branch: branch_taken=1 for one cycle.
  - Required: ifid_flush=1 and idex_flush=1, pc_en=1; flush_events goes 0 -> 1 (macro on).
- Freeze: mem_busy=1 for 3 cycles while in MC_WAIT with mc_cnt=1.
  - Required: all enables 0 and flushes 0 for 3 cycles with mc_cnt still 1; then one more hold cycle, then release; stall_cycles accounts for all of them.
- Reset mid-op: rst=1 during MC_WAIT.
  - Required: while asserted, all flushes are 1 and all enables 0; after release the state is RUN, mc_cnt=0 and the counters are 0.
